dir_cmd_queue: RTL and testbench

Converts the four debounced Pacman buttons into a queue of direction commands for the game controller. It sits between the button debouncers and `gameCtl`. Every press, and every auto-repeat while a single button is held, becomes a 2-bit direction command. Commands are held in a small FIFO until the controller accepts them on its move tick, so no input is lost between ticks.

---
 rtl/dir_cmd_queue.sv | 114 +++++++++++
 tb/tb_dir_cmd_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dir_cmd_queue.sv
// Turns debounced direction buttons (presses and single-button auto-repeat) into 2-bit commands
// held in a small coalescing FIFO until the game controller accepts them.
module dir_cmd_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned REPEAT_DELAY = 12_500_000,
  parameter int unsigned REPEAT_W     = 24,
  localparam int unsigned PW          = $clog2(DEPTH),
  localparam int unsigned LW          = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    btn,
  input  logic          cmd_ready,
  output logic          cmd_valid,
  output logic [1:0]    cmd_dir,
  output logic          overflow,
  output logic [LW-1:0] level
);

  localparam logic [REPEAT_W-1:0] RepLast =
    REPEAT_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);

  logic [3:0]          r_btn_q;
  logic [REPEAT_W-1:0] r_rep_cnt;
  logic [1:0]          r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic                r_overflow;

  logic [3:0]          w_rise;
  logic                w_one_hot;
  logic                w_held;
  logic                w_rep_fire;
  logic [REPEAT_W-1:0] w_rep_cnt_d;
  logic                w_cand_vld;
  logic [1:0]          w_cand_dir;
  logic                w_pop;
  logic [LW-1:0]       w_lvl_pop;
  logic [1:0]          w_tail;
  logic                w_coalesce;
  logic                w_full_pop;
  logic                w_push;
  logic                w_drop;

  // Lowest set index wins: left > up > right > down.
  function automatic logic [1:0] f_low_idx(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign w_rise    = btn & ~r_btn_q;
  assign w_one_hot = (btn != 4'b0000) && ((btn & (btn - 4'd1)) == 4'b0000);
  assign w_held    = w_one_hot && (btn == r_btn_q);

  // A zero delay keeps the counter parked at 0 and never fires.
  always_comb begin
    w_rep_fire  = 1'b0;
    w_rep_cnt_d = '0;
    if ((REPEAT_DELAY != 0) && w_held) begin
      if (r_rep_cnt == RepLast) begin
        w_rep_fire = 1'b1;
      end else begin
        w_rep_cnt_d = r_rep_cnt + REPEAT_W'(1);
      end
    end
  end

  assign w_cand_vld = (w_rise != 4'b0000) || w_rep_fire;
  assign w_cand_dir = (w_rise != 4'b0000) ? f_low_idx(w_rise) : f_low_idx(btn);

  assign cmd_valid  = (r_level != '0);
  assign cmd_dir    = cmd_valid ? r_mem[r_rd_ptr] : 2'b00;
  assign overflow   = r_overflow;
  assign level      = r_level;

  // The tail survives a pop whenever anything remains, so coalescing compares against it.
  assign w_pop      = cmd_valid && cmd_ready;
  assign w_lvl_pop  = r_level - LW'(w_pop);
  assign w_tail     = r_mem[r_wr_ptr - PW'(1)];
  assign w_coalesce = (w_lvl_pop != '0) && (w_tail == w_cand_dir);
  assign w_full_pop = (w_lvl_pop == LW'(DEPTH));
  assign w_push     = w_cand_vld && !w_coalesce && !w_full_pop;
  assign w_drop     = w_cand_vld && !w_coalesce && w_full_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_q    <= 4'b1111;
      r_rep_cnt  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 2'b00;
      end
    end else begin
      r_btn_q    <= btn;
      r_rep_cnt  <= w_rep_cnt_d;
      r_overflow <= w_drop;
      r_level    <= w_lvl_pop + LW'(w_push);
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_cand_dir;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dir_cmd_queue.sv
// Self-checking bench for dir_cmd_queue: per-scenario tasks plus a pop scoreboard on the
// auto-repeat instance; a second instance with repeat disabled covers the reset-held case.
module tb_dir_cmd_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       cmd_ready;

  logic       valid_a, ovf_a;
  logic [1:0] dir_a;
  logic [2:0] lvl_a;
  logic       valid_b, ovf_b;
  logic [1:0] dir_b;
  logic [2:0] lvl_b;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q [$];

  always #5 clk = ~clk;

  dir_cmd_queue #(.DEPTH(4), .REPEAT_DELAY(8), .REPEAT_W(4)) u_dut (
    .clk(clk), .reset(reset), .btn(btn), .cmd_ready(cmd_ready),
    .cmd_valid(valid_a), .cmd_dir(dir_a), .overflow(ovf_a), .level(lvl_a)
  );

  dir_cmd_queue #(.DEPTH(4), .REPEAT_DELAY(0), .REPEAT_W(24)) u_norep (
    .clk(clk), .reset(reset), .btn(btn), .cmd_ready(cmd_ready),
    .cmd_valid(valid_b), .cmd_dir(dir_b), .overflow(ovf_b), .level(lvl_b)
  );

  // Scoreboard: every accepted command on u_dut must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && valid_a && cmd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got dir=%0d, required no command", dir_a);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (dir_a !== e) begin
          failures++;
          $display("FAIL pop_dir: got %0d, required %0d", dir_a, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d);
    btn = 4'(1 << d);
    tick();
    btn = 4'b0000;
    tick();
  endtask

  task automatic do_reset(input logic [3:0] b);
    reset     = 1'b0;
    btn       = b;
    cmd_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset(4'b0000);
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b, required 0", valid_a); end
    checks++; if (lvl_a !== 3'd0) begin failures++; $display("FAIL rst_level: got %0d, required 0", lvl_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b, required 0", ovf_a); end
    checks++; if (dir_a !== 2'b00) begin failures++; $display("FAIL rst_dir: got %0d, required 0", dir_a); end
  endtask

  task automatic test_reset_held();
    do_reset(4'b0001);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (valid_b !== 1'b0) begin
        failures++;
        $display("FAIL held_no_cmd: cycle %0d got valid=%b, required 0", c, valid_b);
      end
      tick();
    end
    btn = 4'b0000;
    tick();
    btn = 4'b0010;
    tick();
    checks++; if (valid_b !== 1'b1) begin failures++; $display("FAIL held_up_valid: got %b, required 1", valid_b); end
    checks++; if (dir_b !== 2'b01) begin failures++; $display("FAIL held_up_dir: got %0d, required 1", dir_b); end
    checks++; if (lvl_b !== 3'd1) begin failures++; $display("FAIL held_up_level: got %0d, required 1", lvl_b); end
    btn = 4'b0000;
  endtask

  task automatic test_simultaneous();
    do_reset(4'b0000);
    btn = 4'b1110;
    tick();
    btn = 4'b0000;
    checks++; if (lvl_a !== 3'd1) begin failures++; $display("FAIL simul_level: got %0d, required 1", lvl_a); end
    checks++; if (dir_a !== 2'b01) begin failures++; $display("FAIL simul_dir: got %0d, required 1", dir_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL simul_overflow: got %b, required 0", ovf_a); end
    exp_q.push_back(2'b01);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++; if (lvl_a !== 3'd0) begin failures++; $display("FAIL simul_pop_level: got %0d, required 0", lvl_a); end
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL simul_pop_valid: got %b, required 0", valid_a); end
  endtask

  task automatic test_overflow();
    int d;
    do_reset(4'b0000);
    for (int i = 0; i < 5; i++) begin
      d = i % 4;
      btn = 4'(1 << d);
      tick();
      btn = 4'b0000;
      checks++;
      if (ovf_a !== (i == 4)) begin
        failures++;
        $display("FAIL ovf_press%0d: got %b, required %b", i, ovf_a, (i == 4));
      end
      tick();
      checks++;
      if (ovf_a !== 1'b0) begin
        failures++;
        $display("FAIL ovf_after%0d: got %b, required 0", i, ovf_a);
      end
    end
    checks++; if (lvl_a !== 3'd4) begin failures++; $display("FAIL ovf_level: got %0d, required 4", lvl_a); end
    for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
    cmd_ready = 1'b1;
    repeat (4) tick();
    cmd_ready = 1'b0;
    checks++; if (lvl_a !== 3'd0) begin failures++; $display("FAIL ovf_drain: got %0d, required 0", lvl_a); end
    // Refill, then push while popping from a full FIFO.
    for (int i = 0; i < 4; i++) begin
      press(i);
      exp_q.push_back(2'(i));
    end
    exp_q.push_back(2'b00);
    btn       = 4'b0001;
    cmd_ready = 1'b1;
    tick();
    btn       = 4'b0000;
    cmd_ready = 1'b0;
    checks++; if (lvl_a !== 3'd4) begin failures++; $display("FAIL full_pp_level: got %0d, required 4", lvl_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL full_pp_overflow: got %b, required 0", ovf_a); end
    checks++; if (dir_a !== 2'b01) begin failures++; $display("FAIL full_pp_head: got %0d, required 1", dir_a); end
    cmd_ready = 1'b1;
    repeat (4) tick();
    cmd_ready = 1'b0;
    checks++; if (lvl_a !== 3'd0) begin failures++; $display("FAIL full_pp_drain: got %0d, required 0", lvl_a); end
  endtask

  task automatic test_coalesce();
    do_reset(4'b0000);
    press(2);
    press(2);
    checks++; if (lvl_a !== 3'd1) begin failures++; $display("FAIL coal_same: got %0d, required 1", lvl_a); end
    press(0);
    checks++; if (lvl_a !== 3'd2) begin failures++; $display("FAIL coal_diff: got %0d, required 2", lvl_a); end
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
    btn       = 4'b0100;
    cmd_ready = 1'b1;
    tick();
    btn       = 4'b0000;
    cmd_ready = 1'b0;
    checks++; if (lvl_a !== 3'd2) begin failures++; $display("FAIL coal_pop_level: got %0d, required 2", lvl_a); end
    checks++; if (dir_a !== 2'b00) begin failures++; $display("FAIL coal_pop_head: got %0d, required 0", dir_a); end
    cmd_ready = 1'b1;
    repeat (2) tick();
    cmd_ready = 1'b0;
    checks++; if (lvl_a !== 3'd0) begin failures++; $display("FAIL coal_drain: got %0d, required 0", lvl_a); end
  endtask

  task automatic test_auto_repeat();
    int bad;
    do_reset(4'b0000);
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(2'b11);
    btn = 4'b1000;
    for (int c = 0; c < 30; c++) begin
      tick();
      checks++;
      if (valid_a !== ((c % 8) == 0)) begin
        failures++;
        $display("FAIL repeat_c%0d: got valid=%b, required %b", c, valid_a, ((c % 8) == 0));
      end
    end
    exp_q.push_back(2'b01);
    btn = 4'b1010;
    tick();
    checks++; if (dir_a !== 2'b01) begin failures++; $display("FAIL repeat_second_dir: got %0d, required 1", dir_a); end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (valid_a !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL repeat_stopped: got %0d valid cycles, required 0", bad); end
    btn       = 4'b0000;
    cmd_ready = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset(4'b0000);
    press(0);
    press(1);
    press(2);
    checks++; if (lvl_a !== 3'd3) begin failures++; $display("FAIL async_pre_level: got %0d, required 3", lvl_a); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL async_valid: got %b, required 0", valid_a); end
    checks++; if (lvl_a !== 3'd0) begin failures++; $display("FAIL async_level: got %0d, required 0", lvl_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL async_overflow: got %b, required 0", ovf_a); end
    exp_q.delete();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset     = 1'b0;
    btn       = 4'b0000;
    cmd_ready = 1'b0;
    test_reset();
    test_reset_held();
    test_simultaneous();
    test_overflow();
    test_coalesce();
    test_auto_repeat();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left: got %0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
